// File: rtl/sa_pkg.sv
// sa_pkg: shared control codes, sequencer state encoding and counter width helpers.
package sa_pkg;
   localparam logic [1:0] CTL_HOLD   = 2'b00;
   localparam logic [1:0] CTL_WR     = 2'b01;
   localparam logic [1:0] CTL_RD     = 2'b10;
   localparam logic [1:0] CTL_CLR    = 2'b11;
   localparam logic [1:0] PE_COMPUTE = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_LOAD_W  = 3'd2,
      S_LOAD_IN = 3'd3,
      S_COMPUTE = 3'd4,
      S_DRAIN   = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   function automatic int beat_bits(input int rows, input int cols, input int vector);
      return $clog2((rows > cols ? rows : cols) * vector + 1);
   endfunction

   function automatic int cycle_bits(input int t_len, input int drain);
      return $clog2(t_len + drain + 1);
   endfunction
endpackage

// File: rtl/sa_sequencer_if.sv
// sa_sequencer_if: host handshake and packed control buses between sequencer and array.
interface sa_sequencer_if #(
   parameter int rows = 4,
   parameter int cols = 4
);
   logic                     start;
   logic                     abort;
   logic                     w_valid;
   logic                     in_valid;
   logic                     w_ready;
   logic                     in_ready;
   logic [rows*cols*2-1:0]   ctlpe;
   logic [rows*2-1:0]        ctlbw;
   logic [cols*2-1:0]        ctlbin;
   logic                     busy;
   logic                     done;
   logic [2:0]               phase;

   modport master (
      output start, abort, w_valid, in_valid,
      input  w_ready, in_ready, ctlpe, ctlbw, ctlbin, busy, done, phase
   );

   modport slave (
      input  start, abort, w_valid, in_valid,
      output w_ready, in_ready, ctlpe, ctlbw, ctlbin, busy, done, phase
   );
endinterface

// File: rtl/sa_skew_decode.sv
// sa_skew_decode: maps compute cycle t to the skewed read/compute wavefront codes.
module sa_skew_decode
   import sa_pkg::*;
#(
   parameter int rows   = 4,
   parameter int cols   = 4,
   parameter int vector = 4,
   parameter int tw     = 4
) (
   input  logic [tw-1:0]            t,
   output logic [rows*cols*2-1:0]   pe,
   output logic [rows*2-1:0]        bw,
   output logic [cols*2-1:0]        bin
);
   genvar r, c;
   for (r = 0; r < rows; r++) begin : g_r
      assign bw[2*r +: 2] = (int'(t) >= r && int'(t) < r + vector) ? CTL_RD : CTL_HOLD;
      for (c = 0; c < cols; c++) begin : g_c
         assign pe[2*(r*cols+c) +: 2] =
            (int'(t) >= r + c && int'(t) < r + c + vector) ? PE_COMPUTE : CTL_HOLD;
      end
   end
   for (c = 0; c < cols; c++) begin : g_bin
      assign bin[2*c +: 2] = (int'(t) >= c && int'(t) < c + vector) ? CTL_RD : CTL_HOLD;
   end
endmodule

// File: rtl/sa_sequencer.sv
// sa_sequencer: per-job clear/load/compute/drain sequencer for the systolic array;
// control codes decode combinationally from the registered state and counters.
module sa_sequencer
   import sa_pkg::*;
#(
   parameter int rows   = 4,
   parameter int cols   = 4,
   parameter int vector = 4,
   parameter int drain  = 2
) (
   input logic           clk,
   input logic           rst,
   sa_sequencer_if.slave bus
);
   localparam int t_len  = vector + rows + cols - 2;
   localparam int beat_w = beat_bits(rows, cols, vector);
   localparam int cyc_w  = cycle_bits(t_len, drain);
   localparam logic [beat_w-1:0] w_last = beat_w'(rows * vector - 1);
   localparam logic [beat_w-1:0] i_last = beat_w'(cols * vector - 1);
   localparam logic [cyc_w-1:0]  t_last = cyc_w'(t_len - 1);
   localparam logic [cyc_w-1:0]  d_last = cyc_w'(t_len + drain - 1);

   state_t                   state;
   logic [beat_w-1:0]        beat;
   logic [cyc_w-1:0]         t;
   logic                     w_acc;
   logic                     in_acc;
   logic [rows*cols*2-1:0]   sk_pe;
   logic [rows*2-1:0]        sk_bw;
   logic [cols*2-1:0]        sk_bin;
   logic [rows*2-1:0]        wr_bw;
   logic [cols*2-1:0]        wr_bin;

   sa_skew_decode #(.rows(rows), .cols(cols), .vector(vector), .tw(cyc_w)) u_skew (
      .t   (t),
      .pe  (sk_pe),
      .bw  (sk_bw),
      .bin (sk_bin)
   );

   // The write code follows the live valid so the buffer captures the beat in its own cycle.
   always_comb begin
      w_acc  = state == S_LOAD_W && bus.w_valid;
      in_acc = state == S_LOAD_IN && bus.in_valid;
      wr_bw  = '0;
      wr_bin = '0;
      for (int i = 0; i < rows; i++) wr_bw[2*i +: 2] = int'(beat) / vector == i ? CTL_WR : CTL_HOLD;
      for (int i = 0; i < cols; i++) wr_bin[2*i +: 2] = int'(beat) / vector == i ? CTL_WR : CTL_HOLD;
   end

   assign bus.w_ready  = state == S_LOAD_W;
   assign bus.in_ready = state == S_LOAD_IN;
   assign bus.busy     = state != S_IDLE;
   assign bus.done     = state == S_DONE;
   assign bus.phase    = state;
   assign bus.ctlpe    = state == S_CLEAR ? {rows*cols{CTL_CLR}} : state == S_COMPUTE ? sk_pe : '0;
   assign bus.ctlbw    = state == S_CLEAR ? {rows{CTL_CLR}} : state == S_COMPUTE ? sk_bw :
                         w_acc ? wr_bw : '0;
   assign bus.ctlbin   = state == S_CLEAR ? {cols{CTL_CLR}} : state == S_COMPUTE ? sk_bin :
                         in_acc ? wr_bin : '0;

   // The cycle counter runs straight on from compute into drain.
   always_ff @(posedge clk) begin
      if (rst || bus.abort) begin
         state <= S_IDLE;
         beat  <= '0;
         t     <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) state <= S_CLEAR;
            S_CLEAR: begin
               state <= S_LOAD_W;
               beat  <= '0;
            end
            S_LOAD_W: if (w_acc) begin
               beat  <= beat == w_last ? '0 : beat + 1'b1;
               state <= beat == w_last ? S_LOAD_IN : S_LOAD_W;
            end
            S_LOAD_IN: if (in_acc) begin
               beat  <= beat == i_last ? '0 : beat + 1'b1;
               t     <= '0;
               state <= beat == i_last ? S_COMPUTE : S_LOAD_IN;
            end
            S_COMPUTE: begin
               t     <= t + 1'b1;
               state <= t == t_last ? S_DRAIN : S_COMPUTE;
            end
            S_DRAIN: begin
               t     <= t == d_last ? '0 : t + 1'b1;
               state <= t == d_last ? S_DONE : S_DRAIN;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sa_sequencer.sv
// tb_sa_sequencer: per-cycle expected control words queued at drive time, checked on negedge.
module tb_sa_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;

   sa_sequencer_if #(.rows(4), .cols(4)) bus();

   sa_sequencer #(.rows(4), .cols(4), .vector(4), .drain(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  phase;
      logic        busy;
      logic        done;
      logic        w_ready;
      logic        in_ready;
      logic [31:0] pe;
      logic [7:0]  bw;
      logic [7:0]  bin;
   } obs_t;

   typedef struct {
      obs_t  e;
      string nm;
   } sb_t;

   typedef struct {
      logic  r, s, a, wv, iv;
      obs_t  e;
      string nm;
   } vec_t;

   sb_t q[$];
   int  n_chk = 0;
   int  n_fail = 0;
   int  n_done = 0;
   int  n;
   bit  killed;
   int  kill_n;
   bit  kill_rst;

   function automatic obs_t mk(input int ph, input bit wr, input bit ir,
                               input logic [31:0] pe, input logic [7:0] bw, input logic [7:0] bin);
      obs_t o;
      o.phase    = 3'(ph);
      o.busy     = ph != 0;
      o.done     = ph == 6;
      o.w_ready  = wr;
      o.in_ready = ir;
      o.pe       = pe;
      o.bw       = bw;
      o.bin      = bin;
      return o;
   endfunction

   // Wavefront for 4x4x4; three cycles are pinned to hand-computed words.
   function automatic obs_t expc(input int t);
      obs_t o;
      if (t == 0) return mk(4, 0, 0, 32'h0000_0002, 8'h02, 8'h02);
      if (t == 3) return mk(4, 0, 0, 32'h020A_2AAA, 8'hAA, 8'hAA);
      if (t == 9) return mk(4, 0, 0, 32'h8000_0000, 8'h00, 8'h00);
      o = mk(4, 0, 0, 32'h0, 8'h0, 8'h0);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (t >= r + c && t < r + c + 4) o.pe[2*(r*4+c)+1] = 1'b1;
      for (int i = 0; i < 4; i++)
         if (t >= i && t < i + 4) begin
            o.bw[2*i+1]  = 1'b1;
            o.bin[2*i+1] = 1'b1;
         end
      return o;
   endfunction

   always @(negedge clk) if (bus.done === 1'b1) n_done++;

   always @(negedge clk) begin
      sb_t  x;
      obs_t g;
      if (q.size() > 0) begin
         x = q.pop_front();
         g.phase    = bus.phase;
         g.busy     = bus.busy;
         g.done     = bus.done;
         g.w_ready  = bus.w_ready;
         g.in_ready = bus.in_ready;
         g.pe       = bus.ctlpe;
         g.bw       = bus.ctlbw;
         g.bin      = bus.ctlbin;
         n_chk++;
         if (g !== x.e) begin
            n_fail++;
            $display("FAIL %s @%0t: got ph=%0d busy=%b done=%b wr=%b ir=%b pe=%h bw=%h bin=%h; want ph=%0d busy=%b done=%b wr=%b ir=%b pe=%h bw=%h bin=%h",
                     x.nm, $time, g.phase, g.busy, g.done, g.w_ready, g.in_ready, g.pe, g.bw, g.bin,
                     x.e.phase, x.e.busy, x.e.done, x.e.w_ready, x.e.in_ready, x.e.pe, x.e.bw, x.e.bin);
         end
      end
   end

   task automatic cyc(input logic r, input logic s, input logic a, input logic wv, input logic iv,
                      input obs_t e, input string nm);
      rst          = r;
      bus.start    = s;
      bus.abort    = a;
      bus.w_valid  = wv;
      bus.in_valid = iv;
      q.push_back('{e: e, nm: nm});
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic wv, input logic iv, input logic s, input obs_t e, input string nm);
      bit k;
      if (killed) return;
      k = n == kill_n;
      cyc(k & kill_rst, s, k & ~kill_rst, wv, iv, e, nm);
      n++;
      if (k) killed = 1'b1;
   endtask

   // kn: job cycle (CLEAR = 0) on which abort or rst is raised; st: compute t for a stray start.
   task automatic run_job(input bit gap, input int kn, input bit kr, input int st);
      int   b;
      int   j;
      logic wv;
      n        = 0;
      killed   = 1'b0;
      kill_n   = kn;
      kill_rst = kr;
      cyc(0, 1, 0, 0, 0, mk(0, 0, 0, 32'h0, 8'h0, 8'h0), "idle_start");
      step(1, 1, 0, mk(1, 0, 0, '1, 8'hFF, 8'hFF), "clear");
      b = 0;
      j = 0;
      while (b < 16 && !killed) begin
         wv = gap ? ~j[0] : 1'b1;
         step(wv, 1, 0, mk(2, 1, 0, 32'h0, wv ? 8'(1 << 2*(b/4)) : 8'h0, 8'h0), "load_w");
         if (wv) b++;
         j++;
      end
      for (int i = 0; i < 16; i++) step(1, 1, 0, mk(3, 0, 1, 32'h0, 8'h0, 8'(1 << 2*(i/4))), "load_in");
      for (int t = 0; t < 10; t++) step(0, 0, t == st, expc(t), "compute");
      step(0, 0, 0, mk(5, 0, 0, 32'h0, 8'h0, 8'h0), "drain0");
      step(0, 0, 0, mk(5, 0, 0, 32'h0, 8'h0, 8'h0), "drain1");
      step(0, 0, 0, mk(6, 0, 0, 32'h0, 8'h0, 8'h0), "done");
      step(0, 0, 0, mk(0, 0, 0, 32'h0, 8'h0, 8'h0), "post_done");
      if (killed) cyc(0, 0, 0, 0, 0, mk(0, 0, 0, 32'h0, 8'h0, 8'h0), "after_kill");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion before 200000");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      obs_t z;
      z = mk(0, 0, 0, 32'h0, 8'h0, 8'h0);
      tbl[0] = '{r: 1, s: 0, a: 0, wv: 1, iv: 1, e: z, nm: "rst_valids"};
      tbl[1] = '{r: 1, s: 1, a: 0, wv: 1, iv: 1, e: z, nm: "rst_start"};
      tbl[2] = '{r: 1, s: 0, a: 0, wv: 0, iv: 0, e: z, nm: "rst_hold"};
      tbl[3] = '{r: 0, s: 1, a: 1, wv: 0, iv: 0, e: z, nm: "start_abort_idle"};
      tbl[4] = '{r: 0, s: 0, a: 0, wv: 0, iv: 0, e: z, nm: "still_idle"};
      tbl[5] = '{r: 0, s: 0, a: 0, wv: 1, iv: 1, e: z, nm: "valid_in_idle"};
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.w_valid  = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) cyc(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].wv, tbl[i].iv, tbl[i].e, tbl[i].nm);
      run_job(0, -1, 0, -1);
      run_job(1, -1, 0, -1);
      run_job(0, 21, 0, -1);
      run_job(0, -1, 0, -1);
      run_job(0, -1, 0, 4);
      run_job(0, 38, 1, -1);
      run_job(0, -1, 0, -1);
      @(negedge clk);
      #1;
      n_chk++;
      if (n_done !== 5) begin
         n_fail++;
         $display("FAIL done_count: got %0d done pulses, want 5", n_done);
      end
      n_chk++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL final_busy: got busy=%b, want 0", bus.busy);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
